// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared soc_bus configuration, request struct and arbiter states
package soc_bus_pkg;

  typedef struct packed {
    int unsigned masters;
    int unsigned timeout_cycles;
  } BusConfig;

  localparam BusConfig BUS_CFG_DEFAULT = '{masters: 2, timeout_cycles: 255};

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } bus_req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first requester at or after ptr, with wrap
module rr_pick #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] pick
);

  logic         found;
  logic [W-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// rtl/soc_bus_arbiter.sv - round-robin, whole-transaction arbiter with watchdog for the soc_bus master port
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int MASTERS        = int'(BUS_CFG_DEFAULT.masters),
  parameter int TIMEOUT_CYCLES = int'(BUS_CFG_DEFAULT.timeout_cycles)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MASTERS-1:0]       m_req,
  input  logic [MASTERS-1:0]       m_we,
  input  logic [MASTERS-1:0][3:0]  m_be,
  input  logic [MASTERS-1:0][31:0] m_addr,
  input  logic [MASTERS-1:0][31:0] m_wdata,
  output logic [31:0]              m_rdata,
  output logic [MASTERS-1:0]       m_ack,
  output logic [MASTERS-1:0]       m_error,
  output logic                     s_req,
  output logic                     s_we,
  output logic [3:0]               s_be,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [31:0]              s_rdata,
  input  logic                     s_ack,
  input  logic                     s_error,
  output logic [MASTERS-1:0]       grant,
  output logic                     timeout
);

  localparam int PTR_W = $clog2(MASTERS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t         state, state_nxt;
  logic [MASTERS-1:0] grant_nxt;
  logic [PTR_W-1:0]   gidx, gidx_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]   wd_cnt, wd_cnt_nxt;

  bus_req_t           reqs [MASTERS];
  bus_req_t           sel;
  logic [MASTERS-1:0] pick;
  logic               busy, g_req, done, wd_fire, abort;

  rr_pick #(.N(MASTERS)) u_pick (
    .req  (m_req),
    .ptr  (rr_ptr),
    .pick (pick)
  );

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      reqs[i] = '{addr: m_addr[i], wdata: m_wdata[i], we: m_we[i], be: m_be[i]};
    end
  end

  assign sel   = reqs[gidx];
  assign busy  = (state == ARB_BUSY);
  assign g_req = m_req[gidx];
  assign done  = busy && (s_ack || s_error);
  // A master that drops its request is abandoned silently, so the watchdog does not also fire on it.
  assign abort   = busy && !g_req && !done;
  assign wd_fire = (TIMEOUT_CYCLES != 0) && busy && g_req && !done && (wd_cnt == WD_LAST);

  assign s_req   = busy && g_req;
  assign s_we    = sel.we;
  assign s_be    = sel.be;
  assign s_addr  = sel.addr;
  assign s_wdata = sel.wdata;
  assign m_rdata = s_rdata;
  // grant is zero outside BUSY, which keeps every response bit quiet while idle.
  assign m_ack   = grant & {MASTERS{s_ack}};
  assign m_error = grant & {MASTERS{s_error || wd_fire}};
  assign timeout = wd_fire;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    gidx_nxt   = gidx;
    rr_ptr_nxt = rr_ptr;
    wd_cnt_nxt = wd_cnt;
    case (state)
      ARB_IDLE: begin
        if (|m_req) begin
          state_nxt = ARB_BUSY;
          grant_nxt = pick;
          for (int i = 0; i < MASTERS; i++) begin
            if (pick[i]) gidx_nxt = PTR_W'(i);
          end
        end
      end
      ARB_BUSY: begin
        if (done || wd_fire || abort) begin
          state_nxt  = ARB_IDLE;
          grant_nxt  = '0;
          wd_cnt_nxt = '0;
          rr_ptr_nxt = (gidx == PTR_W'(MASTERS - 1)) ? '0 : gidx + 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      gidx   <= gidx_nxt;
      rr_ptr <= rr_ptr_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb/tb_soc_bus_arbiter.sv - directed self-checking bench for soc_bus_arbiter (2 masters, watchdog of 4)
module tb_soc_bus_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       m_req;
  logic [1:0]       m_we;
  logic [1:0][3:0]  m_be;
  logic [1:0][31:0] m_addr;
  logic [1:0][31:0] m_wdata;
  logic [31:0]      m_rdata;
  logic [1:0]       m_ack;
  logic [1:0]       m_error;
  logic             s_req;
  logic             s_we;
  logic [3:0]       s_be;
  logic [31:0]      s_addr;
  logic [31:0]      s_wdata;
  logic [31:0]      s_rdata;
  logic             s_ack;
  logic             s_error;
  logic [1:0]       grant;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  soc_bus_arbiter #(.MASTERS(2), .TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .m_error (m_error),
    .s_req   (s_req),
    .s_we    (s_we),
    .s_be    (s_be),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .s_error (s_error),
    .grant   (grant),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    m_req   = '0;
    m_we    = '0;
    m_be    = {4'hF, 4'h3};
    m_addr  = {32'h0000_0100, 32'h0000_0200};
    m_wdata = {32'h1111_1111, 32'h2222_2222};
    s_rdata = '0;
    s_ack   = 1'b0;
    s_error = 1'b0;

    #3;
    chk("rst_s_req", 32'(s_req), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_m_ack", 32'(m_ack), 32'd0);
    chk("rst_m_error", 32'(m_error), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    #5 rst = 1'b0;

    // single master 1, ack in 3rd busy cycle with read data
    tick; m_req = 2'b10;
    #3 chk("single_idle_grant", 32'(grant), 32'd0);
    tick;
    #3 chk("single_grant", 32'(grant), 32'b10);
    chk("single_s_req", 32'(s_req), 32'd1);
    chk("single_s_addr", s_addr, 32'h0000_0100);
    chk("single_s_be", 32'(s_be), 32'hF);
    chk("single_no_ack", 32'(m_ack), 32'd0);
    tick;
    #3 chk("single_wait_s_req", 32'(s_req), 32'd1);
    tick; s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #3 chk("single_m_ack", 32'(m_ack), 32'b10);
    chk("rdata", m_rdata, 32'hDEAD_BEEF);
    chk("single_no_err", 32'(m_error), 32'd0);
    tick; s_ack = 1'b0; m_req = 2'b00;
    #3 chk("single_after_s_req", 32'(s_req), 32'd0);
    chk("single_after_grant", 32'(grant), 32'd0);

    // contention: grants alternate 0,1,0,1
    tick; m_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick;
      #3 chk($sformatf("rr_grant_%0d", k), 32'(grant), (k % 2 == 1) ? 32'b10 : 32'b01);
      chk($sformatf("rr_addr_%0d", k), s_addr, (k % 2 == 1) ? 32'h100 : 32'h200);
      tick; s_ack = 1'b1;
      #3 chk($sformatf("rr_ack_%0d", k), 32'(m_ack), (k % 2 == 1) ? 32'b10 : 32'b01);
      tick; s_ack = 1'b0; m_req = (k == 3) ? 2'b00 : 2'b11;
      #3 chk($sformatf("rr_gap_%0d", k), 32'(s_req), 32'd0);
    end

    // bus error on master 0, pointer then favours master 1
    tick; m_req = 2'b01;
    tick; s_error = 1'b1;
    #3 chk("err_grant", 32'(grant), 32'b01);
    chk("err_m_error", 32'(m_error), 32'b01);
    chk("err_m_ack", 32'(m_ack), 32'd0);
    chk("err_timeout", 32'(timeout), 32'd0);
    tick; s_error = 1'b0; m_req = 2'b11;
    #3 chk("err_idle_grant", 32'(grant), 32'd0);
    chk("err_idle_m_error", 32'(m_error), 32'd0);
    tick; s_ack = 1'b1;
    #3 chk("err_next_grant", 32'(grant), 32'b10);
    chk("err_next_ack", 32'(m_ack), 32'b10);
    tick; s_ack = 1'b0; m_req = 2'b01;
    #3 chk("err_next_idle", 32'(s_req), 32'd0);

    // watchdog: no response, fires in 4th busy cycle
    tick;
    #3 chk("wd_grant", 32'(grant), 32'b01);
    chk("wd_c1", 32'(timeout), 32'd0);
    tick;
    #3 chk("wd_c2", 32'(timeout), 32'd0);
    tick;
    #3 chk("wd_c3", 32'(timeout), 32'd0);
    chk("wd_c3_err", 32'(m_error), 32'd0);
    tick;
    #3 chk("wd_fire", 32'(timeout), 32'd1);
    chk("wd_m_error", 32'(m_error), 32'b01);
    chk("wd_s_req", 32'(s_req), 32'd1);
    tick; m_req = 2'b00;
    #3 chk("wd_after_s_req", 32'(s_req), 32'd0);
    chk("wd_after_timeout", 32'(timeout), 32'd0);

    // async reset mid-busy (pointer points at master 1 beforehand)
    tick; m_req = 2'b11;
    tick;
    #3 chk("ar_grant", 32'(grant), 32'b10);
    #2 rst = 1'b1; s_ack = 1'b1; s_error = 1'b1;
    #1 chk("ar_s_req", 32'(s_req), 32'd0);
    chk("ar_grant0", 32'(grant), 32'd0);
    chk("ar_m_ack", 32'(m_ack), 32'd0);
    chk("ar_m_error", 32'(m_error), 32'd0);
    @(negedge clk); rst = 1'b0; s_ack = 1'b0; s_error = 1'b0;
    tick; s_ack = 1'b1; s_error = 1'b1;
    #3 chk("ar_first_grant", 32'(grant), 32'b01);
    chk("both_m_ack", 32'(m_ack), 32'b01);
    chk("both_m_error", 32'(m_error), 32'b01);
    tick; s_ack = 1'b0; s_error = 1'b0; m_req = 2'b00;
    #3 chk("both_idle", 32'(grant), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_bus_arbiter.md
# soc_bus_arbiter

Shares the single master port of `soc_bus` between several bus masters, for example the CPU instruction fetch, the CPU data port and a DMA engine. Each transaction is granted whole: the winner's request is forwarded downstream until `ack` or `error`, then arbitration reopens. Masters are selected round-robin. A watchdog terminates transactions that never complete and returns an error to the owner.

## Interface
Parameters:
- `MASTERS`, default 2: number of requesting masters, minimum 2.
- `TIMEOUT_CYCLES`, default 255: busy cycles without completion before forced error; 0 disables the watchdog.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `m_req`  in  [MASTERS-1:0]  per-master request; held high until that master sees `ack` or `error`.
- `m_we`  in  [MASTERS-1:0]  per-master write enable.
- `m_be`  in  [MASTERS-1:0][3:0]  per-master byte enables.
- `m_addr`  in  [MASTERS-1:0][31:0]  per-master address.
- `m_wdata`  in  [MASTERS-1:0][31:0]  per-master write data.
- `m_rdata`  out  32  shared read data; valid for the master receiving `ack`.
- `m_ack`  out  [MASTERS-1:0]  completion pulse to the owner only.
- `m_error`  out  [MASTERS-1:0]  error pulse to the owner only, from bus error or timeout.
- `s_req`, `s_we`, `s_be`, `s_addr`, `s_wdata`  out  1/1/4/32/32  downstream request toward `soc_bus` master port.
- `s_rdata`, `s_ack`, `s_error`  in  32/1/1  downstream response.
- `grant`  out  [MASTERS-1:0]  one-hot current owner; 0 when idle.
- `timeout`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- Two states: IDLE and BUSY.
- IDLE:
  - `s_req`=0 and `grant`=0.
  - If any `m_req` bit is set, pick the first requester at or after `rr_ptr`, searching upward with wrap.
  - Register that master as `grant` and go to BUSY.
- BUSY:
  - `s_*` request fields are a combinational mux of the granted master.
  - `s_req` = granted `m_req`.
  - `m_ack[g]` = `s_ack`; `m_error[g]` = `s_error` or watchdog fire.
  - All non-granted `m_ack` and `m_error` bits are 0.
  - `m_rdata` = `s_rdata`, always passed through.
- Completion is `s_ack` or `s_error` in BUSY:
  - Next state IDLE.
  - `rr_ptr` = (g+1) mod MASTERS.
  - Watchdog counter cleared.
- Watchdog:
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - It increments each BUSY cycle without completion.
  - When the counter equals TIMEOUT_CYCLES-1 and no completion is present, that cycle drives `m_error[g]`=1 and `timeout`=1, and the block returns to IDLE.
  - `s_req` drops the next cycle.
- Protocol violation, where the granted `m_req` falls before completion:
  - Abort to IDLE next cycle with no response.
  - `rr_ptr` advances as for a completion.
- Simultaneous `s_ack` and `s_error`: both forwarded unchanged; treated as a single completion.

## Timing
- Reset, asynchronous: state IDLE, `grant`=0, `rr_ptr`=0, counter 0. Hence `s_req`=0, all `m_ack`/`m_error`=0, `timeout`=0 immediately.
- Reset while BUSY aborts the transaction; no response is issued.
- Arbitration latency is 1 cycle: `m_req` seen in cycle N gives `grant` and `s_req` in cycle N+1.
- Response path from `s_ack`/`s_error` to `m_ack`/`m_error` is combinational, 0 cycles.
- After completion in cycle C, the block is in IDLE in cycle C+1 with `s_req`=0.
- The next grant appears in C+2 at the earliest, so there is at least one idle bus cycle between transactions.
- Back-to-back requesters are served strictly alternately. With N requesters active, each is served at least once in every N consecutive grants.

## Structure
- Shared `soc_bus_pkg` holds `BusConfig` and a packed struct `bus_req_t` (addr, wdata, we, be).
- Per-master request inputs may be declared as `bus_req_t [MASTERS-1:0]`.
- Sub-module `rr_pick` is purely combinational: inputs `req` vector and `ptr`, output one-hot `pick`. It is reused by future arbiters.
- FSM, watchdog and muxes live in `soc_bus_arbiter`.

## Test plan
- Single master: `m_req[1]`=1, addr 0x100, `s_ack` 2 cycles after `s_req` -> `grant`=2'b10 in cycle 1, `s_addr`=0x100, `m_ack[1]` pulse, `m_ack[0]` stays 0, then `s_req`=0 for 1 cycle.
- Contention: both masters request continuously, slave acks after 1 cycle -> grants alternate 0,1,0,1 starting with master 0 after reset.
- Read data: `s_rdata`=0xDEADBEEF with `s_ack` for master 1 -> `m_rdata`=0xDEADBEEF and only `m_ack[1]` high in the same cycle.
- Bus error: `s_error`=1 without `s_ack` -> `m_error[g]`=1 for one cycle, FSM returns to IDLE, `rr_ptr` advances.
- Timeout: TIMEOUT_CYCLES=4, slave never responds -> `m_error[g]` and `timeout` high in the 4th BUSY cycle, `s_req` low the next cycle.
- Async reset asserted mid-BUSY between clock edges -> `s_req`, `grant`, `m_ack` and `m_error` go to 0 without waiting for a clock edge; the first grant after release goes to master 0.
